// File: rtl/booth_bist_ctrl_if.sv
// Controller-to-multiplier bus: operands and start pulse out, product and busy back.
interface booth_bist_ctrl_if #(
    parameter int WIDTH = 4
) ();
    logic [WIDTH-1:0]   mult_a;
    logic [WIDTH-1:0]   mult_b;
    logic               mult_start;
    logic [2*WIDTH-1:0] mult_product;
    logic               mult_busy;

    modport master (
        output mult_a, mult_b, mult_start,
        input  mult_product, mult_busy
    );

    modport slave (
        input  mult_a, mult_b, mult_start,
        output mult_product, mult_busy
    );
endinterface

// File: rtl/booth_bist_ctrl.sv
// Sequencer for the signed Booth multiplier: functional pass-through plus exhaustive BIST.
//
// state  | meaning
// IDLE   | waiting for a functional start or a BIST request
// FWAIT  | functional op in flight, waiting for busy to rise then fall
// BISSUE | BIST operands on the bus, start pulse high
// BWAIT  | BIST op in flight, product checked against the golden model on completion
// BDONE  | BIST finished, results shown until test is released
module booth_bist_ctrl #(
    parameter int WIDTH        = 4,
    parameter int NUM_PATTERNS = 256,
    parameter int TIMEOUT      = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               test,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               tmo,
    output logic               bist_done,
    output logic               pass,
    output logic [7:0]         err_count,
    booth_bist_ctrl_if.master  mif
);
    localparam int PW = 2 * WIDTH;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [PW-1:0] LAST_IDX = PW'(NUM_PATTERNS - 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, FWAIT, BISSUE, BWAIT, BDONE} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     idx_q, idx_d;
    logic              seen_q, seen_d;
    logic [TW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  mult_a_q, mult_a_d, mult_b_q, mult_b_d;
    logic              mstart_q, mstart_d;
    logic [PW-1:0]     product_q, product_d;
    logic              tmo_q, tmo_d, done_q, done_d, pass_q, pass_d, busy_q, busy_d;
    logic [7:0]        err_q, err_d;

    logic              in_wait, complete, expired, mismatch;
    logic [PW-1:0]     golden;

    // Sign-extend both operands to product width; the truncated unsigned product is the signed result.
    assign golden   = {{WIDTH{mult_a_q[WIDTH-1]}}, mult_a_q} * {{WIDTH{mult_b_q[WIDTH-1]}}, mult_b_q};
    assign in_wait  = (state_q == FWAIT) || (state_q == BWAIT);
    assign complete = in_wait && seen_q && !mif.mult_busy;
    assign expired  = in_wait && (cnt_q == '0) && !complete;
    assign mismatch = mif.mult_product != golden;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        seen_d    = seen_q | mif.mult_busy;
        cnt_d     = (cnt_q != '0) ? cnt_q - TW'(1) : cnt_q;
        mult_a_d  = mult_a_q;
        mult_b_d  = mult_b_q;
        mstart_d  = 1'b0;
        product_d = product_q;
        tmo_d     = tmo_q;
        done_d    = done_q;
        pass_d    = pass_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (test) begin
                    state_d  = BISSUE;
                    err_d    = '0;
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
                    idx_d    = '0;
                    mult_a_d = '0;
                    mult_b_d = '0;
                    mstart_d = 1'b1;
                end else if (start) begin
                    state_d  = FWAIT;
                    mult_a_d = a;
                    mult_b_d = b;
                    mstart_d = 1'b1;
                    tmo_d    = 1'b0;
                    seen_d   = 1'b0;
                    cnt_d    = TMO_LOAD;
                end
            end
            FWAIT: begin
                if (complete) begin
                    product_d = mif.mult_product;
                    state_d   = IDLE;
                end else if (expired) begin
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            BISSUE: begin
                state_d = BWAIT;
                seen_d  = 1'b0;
                cnt_d   = TMO_LOAD;
            end
            BWAIT: begin
                if (complete || expired) begin
                    if ((expired || mismatch) && (err_q != 8'hFF))
                        err_d = err_q + 8'd1;
                    if (idx_q == LAST_IDX) begin
                        state_d = BDONE;
                        done_d  = 1'b1;
                        pass_d  = (err_d == 8'd0);
                    end else begin
                        idx_d    = idx_q + PW'(1);
                        mult_a_d = idx_d[PW-1:WIDTH];
                        mult_b_d = idx_d[WIDTH-1:0];
                        mstart_d = 1'b1;
                        state_d  = BISSUE;
                    end
                end
            end
            BDONE: begin
                if (!test)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == FWAIT) || (state_d == BISSUE) || (state_d == BWAIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            seen_q    <= 1'b0;
            cnt_q     <= '0;
            mult_a_q  <= '0;
            mult_b_q  <= '0;
            mstart_q  <= 1'b0;
            product_q <= '0;
            tmo_q     <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            seen_q    <= seen_d;
            cnt_q     <= cnt_d;
            mult_a_q  <= mult_a_d;
            mult_b_q  <= mult_b_d;
            mstart_q  <= mstart_d;
            product_q <= product_d;
            tmo_q     <= tmo_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    assign mif.mult_a     = mult_a_q;
    assign mif.mult_b     = mult_b_q;
    assign mif.mult_start = mstart_q;
    assign product        = product_q;
    assign busy           = busy_q;
    assign tmo            = tmo_q;
    assign bist_done      = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
endmodule
